// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory-port arbiter.
// Requester index 0 is instruction fetch, index 1 is load/store.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [2:0] FUNCT3_LW = 3'b010;
    localparam int unsigned REQ_I = 0;
    localparam int unsigned REQ_D = 1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker: grants a lone requester, or the preferred one
// when both request. pref=0 prefers req[0], pref=1 prefers req[1].
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       pref,
    output logic [1:0] gnt
);

    always_comb begin
        if (&req) begin
            gnt = pref ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between fetch and load/store, and
// steers the one-cycle-latency read data back to its owner.
// Define MEM_ARB_RR_EN for round-robin; otherwise load/store has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0] req_v;
    logic [1:0] gnt;
    logic       pref;
    owner_e     state;
    owner_e     state_nxt;

    // Masking requests during reset keeps grants and memory writes quiet.
    assign req_v = {d_req & ~rst, i_req & ~rst};

    arb_pick2 u_pick (
        .req  (req_v),
        .pref (pref),
        .gnt  (gnt)
    );

    assign i_gnt = gnt[REQ_I];
    assign d_gnt = gnt[REQ_D];

`ifdef MEM_ARB_RR_EN
    logic ptr;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt) begin
            ptr <= gnt[REQ_I];
        end
    end

    assign pref = ptr;
`else
    assign pref = 1'b1;
`endif

    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_wen    = 1'b0;
        mem_ra     = '0;
        mem_wa     = '0;
        mem_wd     = '0;
        mem_funct3 = '0;
        if (gnt[REQ_I]) begin
            mem_ra     = i_addr;
            mem_funct3 = FUNCT3_LW;
        end else if (gnt[REQ_D]) begin
            mem_funct3 = d_funct3;
            if (d_we) begin
                mem_wen = 1'b1;
                mem_wa  = d_addr;
                mem_wd  = d_wdata;
            end else begin
                mem_ra = d_addr;
            end
        end
    end

    always_comb begin
        state_nxt = OWN_NONE;
        if (gnt[REQ_I]) begin
            state_nxt = OWN_I;
        end else if (gnt[REQ_D] && !d_we) begin
            state_nxt = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OWN_NONE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gated by rst so a read in flight when reset arrives never returns.
    assign i_rvalid = (state == OWN_I) && !rst;
    assign d_rvalid = (state == OWN_D) && !rst;
    assign i_rdata  = mem_rd;
    assign d_rdata  = mem_rd;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small one-cycle-latency memory model.
// Expectations cover both the fixed-priority and MEM_ARB_RR_EN builds.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_funct3;
    logic        mem_wen;
    logic [31:0] mem_ra, mem_wa, mem_wd, mem_rd;
    logic [2:0]  mem_funct3;

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_errors = 0;
    logic rr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wen(mem_wen), .mem_ra(mem_ra), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_funct3(mem_funct3), .mem_rd(mem_rd)
    );

    // Word-addressed synchronous memory: write and read on the same edge.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_wa[9:2]] <= mem_wd;
        mem_rd <= mem[mem_ra[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs after the falling edge and settle before checking.
    task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic we, input logic [31:0] da,
                         input logic [31:0] wd, input logic [2:0] f3);
        @(negedge clk);
        rst = r; i_req = ir; i_addr = ia;
        d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_funct3 = f3;
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h00A00093;   // 0x100
        mem[8'h41] = 32'h11111111;   // 0x104
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_funct3 = '0;

        // Reset held two cycles with both requesting.
        for (int c = 0; c < 2; c++) begin
            drive(1, 1, 32'h100, 1, 0, 32'h104, 0, 3'b010);
            check("rst_i_gnt", {31'b0, i_gnt}, 0);
            check("rst_d_gnt", {31'b0, d_gnt}, 0);
            check("rst_wen", {31'b0, mem_wen}, 0);
            check("rst_i_rvalid", {31'b0, i_rvalid}, 0);
            check("rst_d_rvalid", {31'b0, d_rvalid}, 0);
        end

        // Contention: four cycles, both requesting.
        drive(0, 1, 32'h100, 1, 0, 32'h104, 0, 3'b010);
        check("c0_i_gnt", {31'b0, i_gnt}, {31'b0, rr});
        check("c0_d_gnt", {31'b0, d_gnt}, {31'b0, !rr});
        check("c0_ra", mem_ra, rr ? 32'h100 : 32'h104);
        check("c0_f3", {29'b0, mem_funct3}, 3'b010);
        check("c0_i_rvalid", {31'b0, i_rvalid}, 0);

        drive(0, 1, 32'h100, 1, 0, 32'h104, 0, 3'b010);
        check("c1_d_gnt", {31'b0, d_gnt}, 1);
        check("c1_i_gnt", {31'b0, i_gnt}, 0);
        check("c1_i_rvalid", {31'b0, i_rvalid}, {31'b0, rr});
        check("c1_d_rvalid", {31'b0, d_rvalid}, {31'b0, !rr});
        check("c1_rdata", rr ? i_rdata : d_rdata, rr ? 32'h00A00093 : 32'h11111111);

        drive(0, 1, 32'h100, 1, 0, 32'h104, 0, 3'b010);
        check("c2_i_gnt", {31'b0, i_gnt}, {31'b0, rr});
        check("c2_d_gnt", {31'b0, d_gnt}, {31'b0, !rr});
        check("c2_d_rvalid", {31'b0, d_rvalid}, 1);
        check("c2_d_rdata", d_rdata, 32'h11111111);

        drive(0, 1, 32'h100, 1, 0, 32'h104, 0, 3'b010);
        check("c3_d_gnt", {31'b0, d_gnt}, 1);
        check("c3_i_rvalid", {31'b0, i_rvalid}, {31'b0, rr});
        check("c3_d_rvalid", {31'b0, d_rvalid}, {31'b0, !rr});

        // Load/store drops: fetch granted in the same cycle.
        drive(0, 1, 32'h100, 0, 0, 32'h104, 0, 3'b010);
        check("drop_i_gnt", {31'b0, i_gnt}, 1);
        check("drop_d_gnt", {31'b0, d_gnt}, 0);
        check("drop_ra", mem_ra, 32'h100);
        check("drop_f3", {29'b0, mem_funct3}, 3'b010);
        check("drop_d_rvalid", {31'b0, d_rvalid}, 1);

        // Idle: fetch data returns, all memory outputs zero.
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 3'b000);
        check("idle_i_rvalid", {31'b0, i_rvalid}, 1);
        check("idle_i_rdata", i_rdata, 32'h00A00093);
        check("idle_d_rvalid", {31'b0, d_rvalid}, 0);
        check("idle_ra", mem_ra, 0);
        check("idle_wa", mem_wa, 0);
        check("idle_wd", mem_wd, 0);
        check("idle_f3", {29'b0, mem_funct3}, 0);
        check("idle_wen", {31'b0, mem_wen}, 0);

        // Store 0xDEADBEEF to 0x200.
        drive(0, 0, 32'h0, 1, 1, 32'h200, 32'hDEADBEEF, 3'b010);
        check("st_d_gnt", {31'b0, d_gnt}, 1);
        check("st_wen", {31'b0, mem_wen}, 1);
        check("st_wa", mem_wa, 32'h200);
        check("st_wd", mem_wd, 32'hDEADBEEF);
        check("st_ra", mem_ra, 0);
        check("st_f3", {29'b0, mem_funct3}, 3'b010);
        check("st_i_rvalid", {31'b0, i_rvalid}, 0);

        // Load back from 0x200.
        drive(0, 0, 32'h0, 1, 0, 32'h200, 32'h0, 3'b010);
        check("ld_d_gnt", {31'b0, d_gnt}, 1);
        check("ld_wen", {31'b0, mem_wen}, 0);
        check("ld_ra", mem_ra, 32'h200);
        check("ld_no_st_rvalid", {31'b0, d_rvalid}, 0);

        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 3'b000);
        check("ld_d_rvalid", {31'b0, d_rvalid}, 1);
        check("ld_d_rdata", d_rdata, 32'hDEADBEEF);
        check("ld_i_rvalid", {31'b0, i_rvalid}, 0);

        // Lone fetch, then reset in the return cycle.
        drive(0, 1, 32'h100, 0, 0, 32'h0, 0, 3'b000);
        check("lf_i_gnt", {31'b0, i_gnt}, 1);
        drive(1, 0, 32'h0, 1, 0, 32'h104, 0, 3'b010);
        check("mr_i_rvalid", {31'b0, i_rvalid}, 0);
        check("mr_d_gnt", {31'b0, d_gnt}, 0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 3'b000);
        check("post_i_rvalid", {31'b0, i_rvalid}, 0);
        check("post_d_rvalid", {31'b0, d_rvalid}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
